sd_cmd_arbiter: RTL

Sequencer and arbiter for the SD-card command path. Two requesters, the audio streaming loop and the UI/file-browser logic, share the single `sys_cmd`/`sys_arg1`/`sys_reqId` command port of `sdcard_controller`. The block grants one command at a time, issues it with a fresh request ID, and waits for the HPS completion (a change in `hReqId[1:0]`). It then returns the response op and data to the owning requester. It sits in the top level between the audio/UI logic and `sdcard_controller`, in the `sd_clk` domain.

---
 rtl/sd_cmd_arbiter.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/sd_cmd_arbiter.sv
// SD command-path arbiter: audio/UI requesters share one sdcard_controller port.
// Define SD_ARB_TIMEOUT_EN to bound WAIT by TIMEOUT_CYCLES with an error response.
module sd_cmd_arbiter #(
    parameter int FILESIZE_WIDTH = 25,
    parameter int AUDIO_BURST    = 4,
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic                    sd_clk,
    input  logic                    sd_rst,
    input  logic                    aud_valid,
    output logic                    aud_ready,
    input  logic [7:0]              aud_cmd,
    input  logic [FILESIZE_WIDTH:0] aud_arg,
    input  logic                    ui_valid,
    output logic                    ui_ready,
    input  logic [7:0]              ui_cmd,
    input  logic [FILESIZE_WIDTH:0] ui_arg,
    input  logic [15:0]             hOp,
    input  logic [31:0]             hData,
    input  logic [15:0]             hReqId,
    output logic [7:0]              sys_cmd,
    output logic [FILESIZE_WIDTH:0] sys_arg1,
    output logic [3:0]              sys_reqId,
    output logic                    aud_rsp_valid,
    output logic                    ui_rsp_valid,
    output logic [3:0]              rsp_op,
    output logic [31:0]             rsp_data,
    output logic                    rsp_err,
    output logic                    evt_valid,
    output logic                    busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]              state_q, state_d;
    logic                    owner_q, owner_d;
    logic [7:0]              cmd_q, cmd_d;
    logic [FILESIZE_WIDTH:0] arg_q, arg_d;
    logic [7:0]              sys_cmd_q, sys_cmd_d;
    logic [FILESIZE_WIDTH:0] sys_arg_q, sys_arg_d;
    logic [3:0]              reqid_q, reqid_d;
    logic [1:0]              shadow_q, shadow_d;
    logic                    init_q;
    logic [3:0]              burst_q, burst_d;
    logic [3:0]              op_q, op_d;
    logic [31:0]             data_q, data_d;
    logic                    aud_rsp_q, aud_rsp_d;
    logic                    ui_rsp_q, ui_rsp_d;
    logic                    evt_q, evt_d;

`ifdef SD_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          err_q, err_d;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

    logic chg, in_idle, burst_full, ui_win, aud_go, ui_go;
    logic unused_bits;

    assign unused_bits = ^{hOp[15:4], hReqId[15:2]};

    // shadow is meaningless until loaded on the first clock after reset
    assign chg        = init_q && (hReqId[1:0] != shadow_q);
    assign in_idle    = (state_q == S_IDLE);
    assign burst_full = (burst_q == 4'(AUDIO_BURST));
    assign ui_win     = ui_valid && (!aud_valid || burst_full);
    assign aud_ready  = in_idle && aud_valid && !ui_win;
    assign ui_ready   = in_idle && ui_win;
    assign aud_go     = aud_valid && aud_ready;
    assign ui_go      = ui_valid && ui_ready;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cmd_d     = cmd_q;
        arg_d     = arg_q;
        sys_cmd_d = sys_cmd_q;
        sys_arg_d = sys_arg_q;
        reqid_d   = reqid_q;
        shadow_d  = shadow_q;
        burst_d   = burst_q;
        op_d      = op_q;
        data_d    = data_q;
        aud_rsp_d = 1'b0;
        ui_rsp_d  = 1'b0;
        evt_d     = 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
        tcnt_d    = tcnt_q;
        err_d     = err_q;
`endif
        if (!init_q)
            shadow_d = hReqId[1:0];

        if (!ui_valid || ui_go)
            burst_d = 4'd0;
        else if (aud_go && !burst_full)
            burst_d = burst_q + 4'd1;

        unique case (state_q)
            S_IDLE: begin
                if (aud_go) begin
                    cmd_d   = aud_cmd;
                    arg_d   = aud_arg;
                    owner_d = 1'b0;
                    state_d = S_ISSUE;
                end else if (ui_go) begin
                    cmd_d   = ui_cmd;
                    arg_d   = ui_arg;
                    owner_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                sys_cmd_d = cmd_q;
                sys_arg_d = arg_q;
                reqid_d   = reqid_q + 4'd1;
                state_d   = S_WAIT;
`ifdef SD_ARB_TIMEOUT_EN
                tcnt_d    = '0;
`endif
            end
            S_WAIT: begin
                if (chg) begin
                    state_d   = S_IDLE;
                    aud_rsp_d = !owner_q;
                    ui_rsp_d  = owner_q;
                end
`ifdef SD_ARB_TIMEOUT_EN
                else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = S_IDLE;
                    aud_rsp_d = !owner_q;
                    ui_rsp_d  = owner_q;
                    op_d      = 4'd0;
                    data_d    = 32'd0;
                    err_d     = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // outside WAIT a response is unsolicited and reported as an event
        if (chg) begin
            shadow_d = hReqId[1:0];
            op_d     = hOp[3:0];
            data_d   = hData;
            evt_d    = (state_q != S_WAIT);
`ifdef SD_ARB_TIMEOUT_EN
            err_d    = 1'b0;
`endif
        end
    end

    always_ff @(posedge sd_clk or posedge sd_rst) begin
        if (sd_rst) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            cmd_q     <= '0;
            arg_q     <= '0;
            sys_cmd_q <= '0;
            sys_arg_q <= '0;
            reqid_q   <= '0;
            shadow_q  <= '0;
            init_q    <= 1'b0;
            burst_q   <= '0;
            op_q      <= '0;
            data_q    <= '0;
            aud_rsp_q <= 1'b0;
            ui_rsp_q  <= 1'b0;
            evt_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cmd_q     <= cmd_d;
            arg_q     <= arg_d;
            sys_cmd_q <= sys_cmd_d;
            sys_arg_q <= sys_arg_d;
            reqid_q   <= reqid_d;
            shadow_q  <= shadow_d;
            init_q    <= 1'b1;
            burst_q   <= burst_d;
            op_q      <= op_d;
            data_q    <= data_d;
            aud_rsp_q <= aud_rsp_d;
            ui_rsp_q  <= ui_rsp_d;
            evt_q     <= evt_d;
        end
    end

`ifdef SD_ARB_TIMEOUT_EN
    always_ff @(posedge sd_clk or posedge sd_rst) begin
        if (sd_rst) begin
            tcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            err_q  <= err_d;
        end
    end

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign sys_cmd       = sys_cmd_q;
    assign sys_arg1      = sys_arg_q;
    assign sys_reqId     = reqid_q;
    assign aud_rsp_valid = aud_rsp_q;
    assign ui_rsp_valid  = ui_rsp_q;
    assign rsp_op        = op_q;
    assign rsp_data      = data_q;
    assign evt_valid     = evt_q;
    assign busy          = !in_idle;

endmodule
